// File: rtl/core_run_ctrl_pkg.sv
// Shared encodings for the core run sequencer: FSM states and the layout
// of the run-status bits as packed into the host status register.
package core_run_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } run_state_t;

   localparam int STAT_IDLE_BIT         = 0;
   localparam int STAT_RUNNING_BIT      = 1;
   localparam int STAT_DONE_BIT         = 2;
   localparam int STAT_TIMEOUT_BIT      = 3;
   localparam int STAT_ABORTED_BIT      = 4;
   localparam int STAT_HOST_BLOCKED_BIT = 5;
   localparam int STAT_W                = 6;

   function automatic logic [STAT_W-1:0] pack_status(
      input logic idle,
      input logic running,
      input logic done,
      input logic timeout,
      input logic aborted,
      input logic host_blocked
   );
      logic [STAT_W-1:0] s;
      s                        = '0;
      s[STAT_IDLE_BIT]         = idle;
      s[STAT_RUNNING_BIT]      = running;
      s[STAT_DONE_BIT]         = done;
      s[STAT_TIMEOUT_BIT]      = timeout;
      s[STAT_ABORTED_BIT]      = aborted;
      s[STAT_HOST_BLOCKED_BIT] = host_blocked;
      return s;
   endfunction

endpackage

// File: rtl/core_run_ctrl_cycle_counter.sv
// Saturating run-cycle counter; clr also latches the budget so it cannot
// change mid-run. budget_hit flags the last cycle allowed by a nonzero budget.
module run_cycle_counter #(
   parameter int CNT_BIT = 31
) (
   input  logic               clk_i,
   input  logic               resetn_i,
   input  logic               clr,
   input  logic               en,
   input  logic [CNT_BIT-1:0] budget_in,
   output logic [CNT_BIT-1:0] cnt,
   output logic               budget_hit
);

   localparam logic [CNT_BIT-1:0] ONE = {{(CNT_BIT-1){1'b0}}, 1'b1};

   logic [CNT_BIT-1:0] budget;

   always_ff @(posedge clk_i) begin
      if (!resetn_i) begin
         cnt    <= '0;
         budget <= '0;
      end else if (clr) begin
         cnt    <= '0;
         budget <= budget_in;
      end else if (en && (cnt != '1)) begin
         cnt <= cnt + ONE;
      end
   end

   // cnt still holds the pre-increment value, so budget-1 marks the B-th cycle
   assign budget_hit = (budget != '0) && (cnt == (budget - ONE));

endmodule

// File: rtl/core_run_ctrl.sv
// Run sequencer between host control registers and the core: start/abort/
// budget handling, run status, and host memory-strobe gating while running.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | waiting for a rising edge on i_run
//   ST_RUN  | core enabled, counting cycles, watching done/abort/budget
//   ST_DONE | run finished; held until i_run is released
module core_run_ctrl
   import core_run_ctrl_pkg::*;
#(
   parameter int CNT_BIT = 31
) (
   input  logic               clk_i,
   input  logic               resetn_i,
   input  logic               i_run,
   input  logic [CNT_BIT-1:0] i_num_cnt,
   input  logic               i_abort,
   input  logic               i_core_done,
   output logic               o_enable,
   output logic               o_idle,
   output logic               o_running,
   output logic               o_done,
   output logic               o_timeout,
   output logic               o_aborted,
   output logic [CNT_BIT-1:0] o_cycle_cnt,
   input  logic               i_host_ce,
   input  logic               i_host_we,
   output logic               o_host_ce,
   output logic               o_host_we,
   output logic               o_host_blocked
);

   run_state_t state;
   run_state_t state_nxt;
   logic       r_run_d;
   logic       start;
   logic       in_run;
   logic       budget_hit;
   logic       exit_done;
   logic       exit_abort;
   logic       exit_budget;

   assign in_run      = (state == ST_RUN);
   assign start       = (state == ST_IDLE) && i_run && !r_run_d;
   // Exit priority: core completion, then abort, then budget expiry
   assign exit_done   = in_run && i_core_done;
   assign exit_abort  = in_run && !i_core_done && i_abort;
   assign exit_budget = in_run && !i_core_done && !i_abort && budget_hit;

   always_ff @(posedge clk_i) begin
      if (!resetn_i) begin
         state   <= ST_IDLE;
         r_run_d <= 1'b0;
      end else begin
         state   <= state_nxt;
         r_run_d <= i_run;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start) state_nxt = ST_RUN;
         ST_RUN:  if (exit_done || exit_abort || exit_budget) state_nxt = ST_DONE;
         ST_DONE: if (!i_run) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      o_idle    = 1'b0;
      o_running = 1'b0;
      o_done    = 1'b0;
      o_enable  = 1'b0;
      case (state)
         ST_IDLE: o_idle = 1'b1;
         ST_RUN: begin
            o_running = 1'b1;
            o_enable  = 1'b1;
         end
         ST_DONE: o_done = 1'b1;
         default: o_idle = 1'b1;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!resetn_i) begin
         o_timeout      <= 1'b0;
         o_aborted      <= 1'b0;
         o_host_blocked <= 1'b0;
      end else if (start) begin
         o_timeout      <= 1'b0;
         o_aborted      <= 1'b0;
         o_host_blocked <= 1'b0;
      end else if (in_run) begin
         if (exit_abort)             o_aborted      <= 1'b1;
         if (exit_budget)            o_timeout      <= 1'b1;
         if (i_host_ce || i_host_we) o_host_blocked <= 1'b1;
      end
   end

   run_cycle_counter #(
      .CNT_BIT(CNT_BIT)
   ) u_cnt (
      .clk_i     (clk_i),
      .resetn_i  (resetn_i),
      .clr       (start),
      .en        (in_run),
      .budget_in (i_num_cnt),
      .cnt       (o_cycle_cnt),
      .budget_hit(budget_hit)
   );

   assign o_host_ce = i_host_ce & ~o_running;
   assign o_host_we = i_host_we & ~o_running;

endmodule

// File: doc/core_run_ctrl.md
Name: core_run_ctrl

Overview:
Run sequencer between the AXI-lite control registers and the RISC-V/matrix-ALU core. It converts the host run request into the core enable, applies an optional cycle budget and an abort, and reports the idle/running/done status. While the core runs, it blocks host-side memory write and chip-enable strobes to IMEM/DMEM/MRAM.

Parameters:
CNT_BIT, 31, width of the cycle budget and cycle counter.

Ports:
clk_i  in  1  core/AXI clock.
resetn_i  in  1  synchronous reset, active low.
i_run  in  1  run request level from the control register; a start is its rising edge.
i_num_cnt  in  CNT_BIT  cycle budget; 0 = unlimited.
i_abort  in  1  host abort request, level.
i_core_done  in  1  completion signal from the core.
o_enable  out  1  core enable.
o_idle  out  1  state is IDLE.
o_running  out  1  state is RUN.
o_done  out  1  state is DONE.
o_timeout  out  1  last run ended on budget expiry.
o_aborted  out  1  last run ended on abort.
o_cycle_cnt  out  CNT_BIT  number of RUN cycles in the current/last run.
i_host_ce  in  1  host memory chip-enable, before gating.
i_host_we  in  1  host memory write-enable, before gating.
o_host_ce  out  1  gated chip-enable.
o_host_we  out  1  gated write-enable.
o_host_blocked  out  1  sticky: host accessed memory during RUN.

Behaviour:
- Synchronous reset, any state: state=IDLE, r_run_d=0, budget=0, cnt=0, all flags 0, o_enable=0, o_idle=1, o_running=0, o_done=0.
- States:
  - IDLE -> RUN when i_run=1 and r_run_d=0. On that edge: latch the budget, clear cnt, o_timeout, o_aborted and o_host_blocked.
  - If i_run is already 1 when reset is released, a start occurs on the first cycle.
- Registered outputs, one-cycle latency:
  - Start detected in cycle N -> o_enable=1 and o_running=1 from cycle N+1.
  - o_enable=1 exactly while state=RUN.
- RUN:
  - cnt increments every cycle and saturates at all-ones.
  - Exit conditions are evaluated on the current cycle, in priority order:
    - i_core_done=1 -> DONE.
    - i_abort=1 -> DONE, set o_aborted.
    - budget!=0 and cnt==budget-1 -> DONE, set o_timeout.
  - The exit cycle still counts. A budget of B gives exactly B enable cycles and o_cycle_cnt=B.
  - A core_done in the k-th RUN cycle gives o_cycle_cnt=k.
- DONE: o_done=1, o_enable=0. Stays in DONE while i_run=1; goes to IDLE on the first cycle i_run=0. Flags and cnt hold until the next start.
- i_run falling during RUN has no effect. Changes to i_num_cnt during RUN are ignored. i_abort and i_core_done outside RUN are ignored.
- Host gating is combinational:
  - o_host_ce = i_host_ce & ~o_running; o_host_we = i_host_we & ~o_running.
  - o_host_blocked is set on the clock edge of any RUN cycle with i_host_ce or i_host_we high; cleared only by reset or a start.
- Exactly one of o_idle, o_running, o_done is 1 at all times.

Decomposition:
- Shared package: state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2; status-bit positions for packing into the AXI status register: {aborted, timeout, done, running, idle} at bits 4..0, plus host_blocked at bit 5.
- One sub-module: run_cycle_counter, a saturating CNT_BIT counter with clear, enable and compare-to-budget flag.

Test Plan:
1. Budget 0, i_run rises, i_core_done pulses in the 10th RUN cycle -> o_enable high for 10 cycles, o_cycle_cnt=10, o_done=1, o_timeout=0.
2. Budget 5, core never done -> o_enable high for exactly 5 cycles, o_timeout=1, o_cycle_cnt=5, state DONE.
3. i_abort and i_core_done both high in the 3rd RUN cycle -> DONE, o_aborted=0, o_cycle_cnt=3; repeat with abort only -> o_aborted=1.
4. i_host_we=1, i_host_ce=1 during RUN -> o_host_we=0, o_host_ce=0, o_host_blocked=1; the same inputs in IDLE pass through and o_host_blocked stays 1 until the next start.
5. resetn_i=0 in the 4th RUN cycle -> next cycle o_idle=1, o_enable=0, o_cycle_cnt=0, flags 0.
6. i_run held high after DONE -> remains DONE, no restart. Drop i_run for 1 cycle -> IDLE; raise it again -> new run with o_timeout, o_aborted and o_host_blocked cleared.
